// File: rtl/bank_cmd_scheduler.sv
// Round-robin arbiter between bank FSM requests, gated by per-bank and bus-wide DRAM timing counters.
// The grant is combinational (stall); the granted command is registered onto cmd_* for the next cycle.
module bank_cmd_scheduler #(
  parameter int NUM_BANKS = 8,
  parameter int T_RCD     = 3,
  parameter int T_RP      = 3,
  parameter int T_RAS     = 6,
  parameter int T_WR      = 3,
  parameter int T_RRD     = 2,
  parameter int T_CCD     = 2,
  parameter int T_WTR     = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_BANKS-1:0]         req_valid,
  input  logic [2*NUM_BANKS-1:0]       req_type,
  output logic [NUM_BANKS-1:0]         stall,
  output logic                         cmd_valid,
  output logic [$clog2(NUM_BANKS)-1:0] cmd_bank,
  output logic [1:0]                   cmd_type
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int BA_W  = $clog2(NUM_BANKS);
  localparam int T_MAX = max2(max2(max2(T_RCD, T_RP), max2(T_RAS, T_WR)),
                              max2(max2(T_RRD, T_CCD), T_WTR));
  // Counters only ever hold T_x-1, so $clog2(T_MAX) bits are enough.
  localparam int CW    = (T_MAX > 2) ? $clog2(T_MAX) : 1;

  localparam logic [1:0] CMD_ACT = 2'b00;
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;
  localparam logic [1:0] CMD_PRE = 2'b11;

  localparam logic [CW-1:0] L_RCD = CW'(T_RCD - 1);
  localparam logic [CW-1:0] L_RP  = CW'(T_RP - 1);
  localparam logic [CW-1:0] L_RAS = CW'(T_RAS - 1);
  localparam logic [CW-1:0] L_WR  = CW'(T_WR - 1);
  localparam logic [CW-1:0] L_RRD = CW'(T_RRD - 1);
  localparam logic [CW-1:0] L_CCD = CW'(T_CCD - 1);
  localparam logic [CW-1:0] L_WTR = CW'(T_WTR - 1);

  function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  logic [CW-1:0]   rcd_q [NUM_BANKS];
  logic [CW-1:0]   rcd_d [NUM_BANKS];
  logic [CW-1:0]   rp_q  [NUM_BANKS];
  logic [CW-1:0]   rp_d  [NUM_BANKS];
  logic [CW-1:0]   ras_q [NUM_BANKS];
  logic [CW-1:0]   ras_d [NUM_BANKS];
  logic [CW-1:0]   wr_q  [NUM_BANKS];
  logic [CW-1:0]   wr_d  [NUM_BANKS];
  logic [CW-1:0]   rrd_q, rrd_d, ccd_q, ccd_d, wtr_q, wtr_d;
  logic [BA_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic [BA_W-1:0] cmd_bank_q, cmd_bank_d;
  logic [1:0]      cmd_type_q, cmd_type_d;

  logic [NUM_BANKS-1:0] elig;
  logic                 grant_vld;
  logic [BA_W-1:0]      grant_idx;
  logic [1:0]           grant_type;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      case (req_type[2*i +: 2])
        CMD_ACT: elig[i] = req_valid[i] && rp_q[i] == '0 && rrd_q == '0;
        CMD_RD:  elig[i] = req_valid[i] && rcd_q[i] == '0 && ccd_q == '0 && wtr_q == '0;
        CMD_WR:  elig[i] = req_valid[i] && rcd_q[i] == '0 && ccd_q == '0;
        default: elig[i] = req_valid[i] && ras_q[i] == '0 && wr_q[i] == '0;
      endcase
    end
  end

  // Reset suppresses the grant so no counter or pointer update can leak through it.
  always_comb begin
    logic [BA_W-1:0] idx;
    idx        = '0;
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_type = CMD_ACT;
    for (int k = 0; k < NUM_BANKS; k++) begin
      idx = BA_W'((int'(rr_ptr_q) + k) % NUM_BANKS);
      if (!rst && !grant_vld && elig[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (grant_vld && grant_idx == BA_W'(i)) grant_type = req_type[2*i +: 2];
    end
  end

  always_comb begin
    stall = '1;
    for (int i = 0; i < NUM_BANKS; i++) begin
      stall[i] = rst || !(grant_vld && grant_idx == BA_W'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      rcd_d[i] = sat_dec(rcd_q[i]);
      rp_d[i]  = sat_dec(rp_q[i]);
      ras_d[i] = sat_dec(ras_q[i]);
      wr_d[i]  = sat_dec(wr_q[i]);
      if (grant_vld && grant_idx == BA_W'(i)) begin
        case (grant_type)
          CMD_ACT: begin
            rcd_d[i] = L_RCD;
            ras_d[i] = L_RAS;
          end
          CMD_WR:  wr_d[i] = L_WR;
          CMD_PRE: rp_d[i] = L_RP;
          default: ;
        endcase
      end
    end
    rrd_d       = sat_dec(rrd_q);
    ccd_d       = sat_dec(ccd_q);
    wtr_d       = sat_dec(wtr_q);
    rr_ptr_d    = rr_ptr_q;
    cmd_valid_d = grant_vld;
    cmd_bank_d  = cmd_bank_q;
    cmd_type_d  = cmd_type_q;
    if (grant_vld) begin
      case (grant_type)
        CMD_ACT: rrd_d = L_RRD;
        CMD_RD:  ccd_d = L_CCD;
        CMD_WR: begin
          ccd_d = L_CCD;
          wtr_d = L_WTR;
        end
        default: ;
      endcase
      rr_ptr_d   = (grant_idx == BA_W'(NUM_BANKS - 1)) ? '0 : grant_idx + 1'b1;
      cmd_bank_d = grant_idx;
      cmd_type_d = grant_type;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        rcd_q[i] <= '0;
        rp_q[i]  <= '0;
        ras_q[i] <= '0;
        wr_q[i]  <= '0;
      end
      rrd_q       <= '0;
      ccd_q       <= '0;
      wtr_q       <= '0;
      rr_ptr_q    <= '0;
      cmd_valid_q <= 1'b0;
      cmd_bank_q  <= '0;
      cmd_type_q  <= '0;
    end else begin
      rcd_q       <= rcd_d;
      rp_q        <= rp_d;
      ras_q       <= ras_d;
      wr_q        <= wr_d;
      rrd_q       <= rrd_d;
      ccd_q       <= ccd_d;
      wtr_q       <= wtr_d;
      rr_ptr_q    <= rr_ptr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_bank_q  <= cmd_bank_d;
      cmd_type_q  <= cmd_type_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_bank  = cmd_bank_q;
  assign cmd_type  = cmd_type_q;

endmodule

// File: tb/tb_bank_cmd_scheduler.sv
// Bench for bank_cmd_scheduler: directed timing scenarios plus random traffic, all checked
// against a model that tracks the cycle of each past command and applies the timing rules as gaps.
module tb_bank_cmd_scheduler;
  localparam int NB    = 8;
  localparam int T_RCD = 3;
  localparam int T_RP  = 3;
  localparam int T_RAS = 6;
  localparam int T_WR  = 3;
  localparam int T_RRD = 2;
  localparam int T_CCD = 2;
  localparam int T_WTR = 3;
  localparam logic [1:0] ACT = 2'b00, RD = 2'b01, WR = 2'b10, PRE = 2'b11;
  localparam int NEVER = -1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] req_valid = '0;
  logic [15:0]   req_type = '0;
  logic [NB-1:0] stall;
  logic          cmd_valid;
  logic [2:0]    cmd_bank;
  logic [1:0]    cmd_type;

  int n_cmp = 0;
  int n_err = 0;

  bank_cmd_scheduler #(
    .NUM_BANKS(NB), .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .T_WR(T_WR),
    .T_RRD(T_RRD), .T_CCD(T_CCD), .T_WTR(T_WTR)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_type(req_type),
    .stall(stall), .cmd_valid(cmd_valid), .cmd_bank(cmd_bank), .cmd_type(cmd_type)
  );

  always #5 clk = ~clk;

  // Reference model: cycle stamps of the last relevant commands.
  int cyc = 0;
  int ptr = 0;
  int l_act [NB];
  int l_pre [NB];
  int l_wr  [NB];
  int g_act, g_cas, g_wr;
  logic       m_cv = 1'b0;
  logic [2:0] m_cb = '0;
  logic [1:0] m_ct = '0;

  function automatic logic [1:0] type_of(input logic [15:0] ty, input int i);
    return 2'(ty >> (2 * i));
  endfunction

  function automatic bit m_elig(input int i, input logic [1:0] t);
    case (t)
      ACT:     return (cyc - l_pre[i] >= T_RP) && (cyc - g_act >= T_RRD);
      RD:      return (cyc - l_act[i] >= T_RCD) && (cyc - g_cas >= T_CCD) && (cyc - g_wr >= T_WTR);
      WR:      return (cyc - l_act[i] >= T_RCD) && (cyc - g_cas >= T_CCD);
      default: return (cyc - l_act[i] >= T_RAS) && (cyc - l_wr[i] >= T_WR);
    endcase
  endfunction

  function automatic int m_grant(input logic r, input logic [NB-1:0] v, input logic [15:0] ty);
    if (r) return -1;
    for (int k = 0; k < NB; k++) begin
      int i;
      i = (ptr + k) % NB;
      if (v[i] && m_elig(i, type_of(ty, i))) return i;
    end
    return -1;
  endfunction

  function automatic logic [NB-1:0] m_stall(input int g);
    if (g < 0) return '1;
    return ~(8'h01 << g);
  endfunction

  task automatic m_commit(input int g, input logic r, input logic [15:0] ty);
    logic [1:0] t;
    if (r) begin
      for (int i = 0; i < NB; i++) begin
        l_act[i] = NEVER; l_pre[i] = NEVER; l_wr[i] = NEVER;
      end
      g_act = NEVER; g_cas = NEVER; g_wr = NEVER;
      ptr = 0; m_cv = 1'b0; m_cb = '0; m_ct = '0;
    end else if (g >= 0) begin
      t = type_of(ty, g);
      case (t)
        ACT: begin l_act[g] = cyc; g_act = cyc; end
        RD:  g_cas = cyc;
        WR:  begin g_cas = cyc; g_wr = cyc; l_wr[g] = cyc; end
        default: l_pre[g] = cyc;
      endcase
      ptr = (g + 1) % NB;
      m_cv = 1'b1; m_cb = 3'(g); m_ct = t;
    end else begin
      m_cv = 1'b0;
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0;
    @(posedge clk); m_commit(-1, 1'b1, '0); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] ty;
    ty = 16'($urandom);
    rst = 1'b1; req_valid = 8'hFF; req_type = ty;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++; if (stall !== 8'hFF) begin n_err++; $display("FAIL reset_stall cyc=%0d got=%b exp=%b", cyc, stall, 8'hFF); end
      @(posedge clk); m_commit(-1, 1'b1, ty); #1;
    end
    rst = 1'b0; req_valid = '0;
    @(negedge clk);
    n_cmp++; if (stall !== 8'hFF) begin n_err++; $display("FAIL reset_idle_stall got=%b exp=%b", stall, 8'hFF); end
    n_cmp++; if ({cmd_valid, cmd_bank, cmd_type} !== 6'b0) begin n_err++; $display("FAIL reset_cmd got=%b/%0d/%0d exp=0/0/0", cmd_valid, cmd_bank, cmd_type); end
    @(posedge clk); m_commit(-1, 1'b0, '0); #1;
  endtask

  task automatic test_single_bank();
    logic [NB-1:0] v, es;
    logic [15:0] ty;
    int g, t0, rd_at;
    do_reset();
    v = 8'h04; ty = '0; t0 = cyc; rd_at = -1;
    for (int k = 0; k < 8; k++) begin
      req_valid = v; req_type = ty;
      @(negedge clk);
      g = m_grant(rst, v, ty); es = m_stall(g);
      n_cmp++; if (stall !== es) begin n_err++; $display("FAIL single_stall cyc=%0d got=%b exp=%b", cyc, stall, es); end
      n_cmp++; if ({cmd_valid, cmd_bank, cmd_type} !== {m_cv, m_cb, m_ct}) begin n_err++; $display("FAIL single_cmd cyc=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", cyc, cmd_valid, cmd_bank, cmd_type, m_cv, m_cb, m_ct); end
      if (g == 2 && ty[5:4] == RD) rd_at = cyc - t0;
      @(posedge clk); m_commit(g, rst, ty); #1;
      if (g == 2) begin
        if (ty[5:4] == ACT) ty[5:4] = RD;
        else v = '0;
      end
    end
    n_cmp++; if (rd_at !== T_RCD) begin n_err++; $display("FAIL single_rd_delay got=%0d exp=%0d", rd_at, T_RCD); end
  endtask

  task automatic test_round_robin();
    logic [NB-1:0] v, es;
    logic [15:0] ty;
    int g, n;
    int ord [3];
    int at  [3];
    do_reset();
    v = 8'h08; ty = 16'h5555; n = 0;
    ord = '{-1, -1, -1}; at = '{-1, -1, -1};
    for (int k = 0; k < 10; k++) begin
      if (k == 3) v = 8'h29;
      req_valid = v; req_type = ty;
      @(negedge clk);
      g = m_grant(rst, v, ty); es = m_stall(g);
      n_cmp++; if (stall !== es) begin n_err++; $display("FAIL rr_stall cyc=%0d got=%b exp=%b", cyc, stall, es); end
      n_cmp++; if ({cmd_valid, cmd_bank, cmd_type} !== {m_cv, m_cb, m_ct}) begin n_err++; $display("FAIL rr_cmd cyc=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", cyc, cmd_valid, cmd_bank, cmd_type, m_cv, m_cb, m_ct); end
      if (k >= 3 && g >= 0 && n < 3) begin ord[n] = g; at[n] = k - 3; n++; end
      @(posedge clk); m_commit(g, rst, ty); #1;
      if (g >= 0) v[g] = 1'b0;
    end
    n_cmp++; if (ord[0] !== 5 || ord[1] !== 0 || ord[2] !== 3) begin n_err++; $display("FAIL rr_order got=%0d,%0d,%0d exp=5,0,3", ord[0], ord[1], ord[2]); end
    n_cmp++; if (at[0] !== 0 || at[1] !== T_CCD || at[2] !== 2 * T_CCD) begin n_err++; $display("FAIL rr_spacing got=%0d,%0d,%0d exp=0,2,4", at[0], at[1], at[2]); end
  endtask

  task automatic test_wtr();
    logic [NB-1:0] v, es;
    logic [15:0] ty;
    int g, rd_at;
    do_reset();
    v = 8'h02; ty = '0; ty[3:2] = WR; ty[9:8] = RD; rd_at = -1;
    for (int k = 0; k < 6; k++) begin
      req_valid = v; req_type = ty;
      @(negedge clk);
      g = m_grant(rst, v, ty); es = m_stall(g);
      n_cmp++; if (stall !== es) begin n_err++; $display("FAIL wtr_stall cyc=%0d got=%b exp=%b", cyc, stall, es); end
      n_cmp++; if ({cmd_valid, cmd_bank, cmd_type} !== {m_cv, m_cb, m_ct}) begin n_err++; $display("FAIL wtr_cmd cyc=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", cyc, cmd_valid, cmd_bank, cmd_type, m_cv, m_cb, m_ct); end
      if (g == 4) rd_at = k;
      @(posedge clk); m_commit(g, rst, ty); #1;
      if (g == 1) v = 8'h10;
      else if (g == 4) v = '0;
    end
    n_cmp++; if (rd_at !== T_WTR) begin n_err++; $display("FAIL wtr_rd_delay got=%0d exp=%0d", rd_at, T_WTR); end
  endtask

  task automatic test_pre_timing();
    logic [NB-1:0] v, es;
    logic [15:0] ty;
    int g, stage;
    int gk [3];
    do_reset();
    v = 8'h40; ty = '0; stage = 0; gk = '{-1, -1, -1};
    for (int k = 0; k < 12; k++) begin
      req_valid = v; req_type = ty;
      @(negedge clk);
      g = m_grant(rst, v, ty); es = m_stall(g);
      n_cmp++; if (stall !== es) begin n_err++; $display("FAIL pre_stall cyc=%0d got=%b exp=%b", cyc, stall, es); end
      n_cmp++; if ({cmd_valid, cmd_bank, cmd_type} !== {m_cv, m_cb, m_ct}) begin n_err++; $display("FAIL pre_cmd cyc=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", cyc, cmd_valid, cmd_bank, cmd_type, m_cv, m_cb, m_ct); end
      @(posedge clk); m_commit(g, rst, ty); #1;
      if (g == 6 && stage < 3) begin
        gk[stage] = k; stage++;
        ty[13:12] = (stage == 1) ? PRE : ACT;
        if (stage == 3) v = '0;
      end
    end
    n_cmp++; if (gk[1] !== T_RAS) begin n_err++; $display("FAIL pre_ras got=%0d exp=%0d", gk[1], T_RAS); end
    n_cmp++; if (gk[2] !== T_RAS + T_RP) begin n_err++; $display("FAIL pre_rp got=%0d exp=%0d", gk[2], T_RAS + T_RP); end
  endtask

  task automatic test_reset_mid();
    logic [NB-1:0] v, es;
    logic [15:0] ty;
    int g, rd_at;
    do_reset();
    v = 8'h20; ty = '0; rd_at = -1;
    for (int k = 0; k < 5; k++) begin
      req_valid = v; req_type = ty;
      @(negedge clk);
      g = m_grant(rst, v, ty); es = m_stall(g);
      n_cmp++; if (stall !== es) begin n_err++; $display("FAIL rstmid_stall cyc=%0d got=%b exp=%b", cyc, stall, es); end
      n_cmp++; if ({cmd_valid, cmd_bank, cmd_type} !== {m_cv, m_cb, m_ct}) begin n_err++; $display("FAIL rstmid_cmd cyc=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", cyc, cmd_valid, cmd_bank, cmd_type, m_cv, m_cb, m_ct); end
      if (g == 5 && ty[11:10] == RD) rd_at = k;
      @(posedge clk); m_commit(g, rst, ty); #1;
      rst = (k == 0);
      if (g == 5) begin
        if (ty[11:10] == ACT) ty[11:10] = RD;
        else v = '0;
      end
    end
    n_cmp++; if (rd_at !== 2) begin n_err++; $display("FAIL rstmid_rd_delay got=%0d exp=2", rd_at); end
  endtask

  task automatic test_random();
    logic [NB-1:0] v, es;
    logic [15:0] ty;
    int g;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      v = 8'($urandom) & 8'($urandom);
      ty = 16'($urandom);
      rst = ($urandom_range(0, 39) == 0);
      req_valid = v; req_type = ty;
      @(negedge clk);
      g = m_grant(rst, v, ty); es = m_stall(g);
      n_cmp++; if (stall !== es) begin n_err++; $display("FAIL rand_stall cyc=%0d got=%b exp=%b", cyc, stall, es); end
      n_cmp++; if ({cmd_valid, cmd_bank, cmd_type} !== {m_cv, m_cb, m_ct}) begin n_err++; $display("FAIL rand_cmd cyc=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", cyc, cmd_valid, cmd_bank, cmd_type, m_cv, m_cb, m_ct); end
      @(posedge clk); m_commit(g, rst, ty); #1;
    end
    rst = 1'b0; req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_bank();
    test_round_robin();
    test_wtr();
    test_pre_timing();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
